// File: rtl/exec_sequencer_if.sv
// Handshake and control bundle between a requester and exec_sequencer.
interface exec_sequencer_if;
  logic       issue_valid;
  logic       issue_ready;
  logic       issue_unit;
  logic [3:0] issue_aluctrl;
  logic       issue_fpuctrl;
  logic [3:0] ALUctrl;
  logic       FPUctrl;
  logic       gp_branch;
  logic       fp_branch;
  logic       result_latch;
  logic       result_sel;
  logic       branch_taken;
  logic       result_valid;
  logic       result_ready;
  logic       busy;

  modport slave (
    input  issue_valid, issue_unit, issue_aluctrl, issue_fpuctrl,
           gp_branch, fp_branch, result_ready,
    output issue_ready, ALUctrl, FPUctrl, result_latch, result_sel,
           branch_taken, result_valid, busy
  );

  modport master (
    output issue_valid, issue_unit, issue_aluctrl, issue_fpuctrl,
           gp_branch, fp_branch, result_ready,
    input  issue_ready, ALUctrl, FPUctrl, result_latch, result_sel,
           branch_taken, result_valid, busy
  );
endinterface

// File: rtl/exec_sequencer.sv
// One-op-at-a-time ALU/FPU execute sequencer with result handshake.
// Define FPU_MUL_MULTICYCLE_EN to give FPU multiply its own MUL_LAT latency.
module exec_sequencer #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  exec_sequencer_if.slave   bus
);

  if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_add_lat
    $error("exec_sequencer: ADD_LAT out of range 1..15");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("exec_sequencer: MUL_LAT out of range 1..15");
  end

  typedef enum logic [1:0] {IDLE, ALU_EXEC, FPU_WAIT, DONE} state_t;

  localparam logic [3:0] ADD_LD = 4'(ADD_LAT - 1);
`ifdef FPU_MUL_MULTICYCLE_EN
  localparam logic [3:0] MUL_LD = 4'(MUL_LAT - 1);
`else
  localparam logic [3:0] MUL_LD = ADD_LD;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       latch;
  logic       accept;

  assign accept = bus.issue_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.issue_valid) begin
          if (bus.issue_unit) begin
            state_nxt = FPU_WAIT;
            cnt_nxt   = bus.issue_fpuctrl ? MUL_LD : ADD_LD;
          end else begin
            state_nxt = ALU_EXEC;
          end
        end
      end
      ALU_EXEC: begin
        latch     = 1'b1;
        state_nxt = DONE;
      end
      FPU_WAIT: begin
        if (cnt == 4'd0) begin
          latch     = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        // Return to IDLE only; the next accept needs a fresh IDLE cycle.
        if (bus.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      bus.ALUctrl      <= 4'd0;
      bus.FPUctrl      <= 1'b0;
      bus.result_sel   <= 1'b0;
      bus.branch_taken <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        bus.ALUctrl    <= bus.issue_aluctrl;
        bus.FPUctrl    <= bus.issue_fpuctrl;
        bus.result_sel <= bus.issue_unit;
      end
      if (latch) bus.branch_taken <= bus.result_sel ? bus.fp_branch : bus.gp_branch;
    end
  end

  assign bus.issue_ready  = (state == IDLE);
  assign bus.result_latch = latch;
  assign bus.result_valid = (state == DONE);
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized self-checking bench for exec_sequencer against a per-op latency model.
module tb_exec_sequencer;
  localparam int ADD = 2;
  localparam int MUL = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_alu;
  logic       exp_fpu;
  logic       exp_sel;
  logic       exp_br;

  exec_sequencer_if bus ();

  exec_sequencer #(.ADD_LAT(ADD), .MUL_LAT(MUL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from accept to the result_latch cycle, from the op's opcode alone.
  function automatic int op_lat(input bit unit, input bit fpu);
    if (!unit) return 1;
`ifdef FPU_MUL_MULTICYCLE_EN
    return fpu ? MUL : ADD;
`else
    return ADD;
`endif
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_aluctrl"}, bus.ALUctrl, 0);
    chk({tag, "_fpuctrl"}, bus.FPUctrl, 0);
    chk({tag, "_sel"}, bus.result_sel, 0);
    chk({tag, "_br"}, bus.branch_taken, 0);
    chk({tag, "_latch"}, bus.result_latch, 0);
    chk({tag, "_valid"}, bus.result_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ready"}, bus.issue_ready, 1);
  endtask

  task automatic do_op(input bit unit, input logic [3:0] alu, input bit fpu,
                       input bit br, input int rdly);
    int lat;
    lat = op_lat(unit, fpu);
    @(negedge clk);
    chk("idle_issue_ready", bus.issue_ready, 1);
    bus.issue_valid   = 1'b1;
    bus.issue_unit    = unit;
    bus.issue_aluctrl = alu;
    bus.issue_fpuctrl = fpu;
    @(posedge clk);
    exp_alu = alu;
    exp_fpu = fpu;
    exp_sel = unit;
    for (int n = 1; n <= lat + 1 + rdly; n++) begin
      @(negedge clk);
      chk("latch", bus.result_latch, (n == lat) ? 1 : 0);
      chk("valid", bus.result_valid, (n > lat) ? 1 : 0);
      chk("busy", bus.busy, 1);
      chk("issue_ready_busy", bus.issue_ready, 0);
      chk("aluctrl", bus.ALUctrl, exp_alu);
      chk("fpuctrl", bus.FPUctrl, exp_fpu);
      if (n > lat) begin
        chk("sel", bus.result_sel, exp_sel);
        chk("branch", bus.branch_taken, exp_br);
      end
      // Issue side is noise while busy and must be ignored.
      bus.issue_valid   = 1'($urandom);
      bus.issue_unit    = 1'($urandom);
      bus.issue_aluctrl = 4'($urandom);
      bus.issue_fpuctrl = 1'($urandom);
      bus.gp_branch     = 1'($urandom);
      bus.fp_branch     = 1'($urandom);
      if (n == lat) begin
        if (unit) bus.fp_branch = br;
        else      bus.gp_branch = br;
        exp_br = br;
      end
      bus.result_ready = (n >= lat + 1 + rdly);
    end
    @(negedge clk);
    chk("post_busy", bus.busy, 0);
    chk("post_issue_ready", bus.issue_ready, 1);
    chk("post_valid", bus.result_valid, 0);
    chk("post_latch", bus.result_latch, 0);
    bus.issue_valid   = 1'b0;
    bus.issue_aluctrl = 4'($urandom);
    bus.issue_fpuctrl = 1'($urandom);
    bus.result_ready  = 1'b0;
    @(negedge clk);
    chk("idle_hold_alu", bus.ALUctrl, exp_alu);
    chk("idle_hold_fpu", bus.FPUctrl, exp_fpu);
    chk("idle_hold_br", bus.branch_taken, exp_br);
  endtask

  initial begin
    int lat;
    int k;
    reset             = 1'b1;
    bus.issue_valid   = 1'b0;
    bus.issue_unit    = 1'b0;
    bus.issue_aluctrl = 4'd0;
    bus.issue_fpuctrl = 1'b0;
    bus.gp_branch     = 1'b0;
    bus.fp_branch     = 1'b0;
    bus.result_ready  = 1'b0;
    exp_alu = 4'd0; exp_fpu = 1'b0; exp_sel = 1'b0; exp_br = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    // Reset wins over a simultaneous issue.
    bus.issue_valid   = 1'b1;
    bus.issue_unit    = 1'b1;
    bus.issue_aluctrl = 4'd9;
    @(negedge clk);
    chk_reset_vals("rst_prio");
    bus.issue_valid = 1'b0;
    reset = 1'b0;

    do_op(1'b0, 4'd7, 1'b0, 1'b1, 0);   // ALU op, branch taken
    do_op(1'b1, 4'd3, 1'b0, 1'b0, 0);   // FPU add
    do_op(1'b1, 4'd5, 1'b1, 1'b1, 0);   // FPU multiply
    do_op(1'b1, 4'd12, 1'b1, 1'b1, 6);  // stall in DONE
    do_op(1'b0, 4'd15, 1'b1, 1'b0, 6);

    for (int i = 0; i < 24; i++)
      do_op(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 4)));

    // Abort a multiply mid-wait, before its latch cycle.
    lat = op_lat(1'b1, 1'b1);
    k = (lat > 2) ? 2 : 1;
    @(negedge clk);
    bus.issue_valid   = 1'b1;
    bus.issue_unit    = 1'b1;
    bus.issue_aluctrl = 4'd10;
    bus.issue_fpuctrl = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= k; n++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      chk("abort_latch", bus.result_latch, 0);
      chk("abort_busy", bus.busy, 1);
      if (n == k) reset = 1'b1;
    end
    @(negedge clk);
    chk_reset_vals("abort");
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_latch", bus.result_latch, 0);
      chk("abort_no_valid", bus.result_valid, 0);
    end
    exp_alu = 4'd0; exp_fpu = 1'b0; exp_br = 1'b0;

    do_op(1'b1, 4'd1, 1'b0, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
